// File: rtl/packed_sum_unpacker_if.sv
// Stream bundle between the adder result source, the packed-sum unpacker and its sink.
// The source side drives the packed word in; the sink side drives out_ready back.
interface packed_sum_unpacker_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 32
);
  logic                 choose_8bit;
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_lane;
  logic                 out_last;

  modport master (
    output choose_8bit, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_last
  );

  modport slave (
    input  choose_8bit, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_last
  );
endinterface

// File: rtl/packed_sum_unpacker.sv
// Splits a packed adder result into two sign-extended lanes, or passes a full-width
// word through, as registered valid/ready beats.
module packed_sum_unpacker #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  packed_sum_unpacker_if.slave bus
);

  localparam int HALF = IN_WIDTH / 2;

  typedef enum logic [1:0] {
    IDLE,
    EMIT_LO,
    EMIT_HI
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [IN_WIDTH-1:0]  r_hold;
  logic                 r_mode;

  logic                 r_out_valid;
  logic [OUT_WIDTH-1:0] r_out_data;
  logic                 r_out_lane;
  logic                 r_out_last;

  logic                 w_out_valid_nxt;
  logic [OUT_WIDTH-1:0] w_out_data_nxt;
  logic                 w_out_lane_nxt;
  logic                 w_out_last_nxt;

  logic                 w_out_fire;
  logic                 w_in_ready;
  logic                 w_in_fire;
  logic [IN_WIDTH-1:0]  w_src;
  logic [HALF-1:0]      w_lane0;
  logic [HALF-1:0]      w_lane1;

  function automatic logic [OUT_WIDTH-1:0] sext_half(input logic [HALF-1:0] v);
    logic [OUT_WIDTH-1:0] res;
    res           = {OUT_WIDTH{v[HALF-1]}};
    res[HALF-1:0] = v;
    return res;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] sext_full(input logic [IN_WIDTH-1:0] v);
    logic [OUT_WIDTH-1:0] res;
    res               = {OUT_WIDTH{v[IN_WIDTH-1]}};
    res[IN_WIDTH-1:0] = v;
    return res;
  endfunction

  assign w_out_fire = r_out_valid && bus.out_ready;
  assign w_in_ready = !reset && ((r_state == IDLE) || (w_out_fire && r_out_last));
  assign w_in_fire  = bus.in_valid && w_in_ready;

  // A freshly accepted word feeds its first beat straight from in_data; lane1 comes from the hold register.
  assign w_src   = w_in_fire ? bus.in_data : r_hold;
  assign w_lane0 = w_src[HALF-1:0];
  assign w_lane1 = w_src[IN_WIDTH-1:HALF];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_mode      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_lane  <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_lane  <= w_out_lane_nxt;
      r_out_last  <= w_out_last_nxt;
      if (w_in_fire) begin
        r_hold <= bus.in_data;
        r_mode <= bus.choose_8bit;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_in_fire) w_state_nxt = EMIT_LO;
      end
      EMIT_LO: begin
        if (w_out_fire) begin
          if (r_mode)         w_state_nxt = EMIT_HI;
          else if (w_in_fire) w_state_nxt = EMIT_LO;
          else                w_state_nxt = IDLE;
        end
      end
      EMIT_HI: begin
        if (w_out_fire) w_state_nxt = w_in_fire ? EMIT_LO : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next value of the registered beat; held unchanged while the sink stalls.
  always_comb begin
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_lane_nxt  = r_out_lane;
    w_out_last_nxt  = r_out_last;
    if (w_in_fire) begin
      w_out_valid_nxt = 1'b1;
      w_out_lane_nxt  = 1'b0;
      w_out_last_nxt  = !bus.choose_8bit;
      w_out_data_nxt  = bus.choose_8bit ? sext_half(w_lane0) : sext_full(w_src);
    end else if (w_out_fire) begin
      if ((r_state == EMIT_LO) && r_mode) begin
        w_out_valid_nxt = 1'b1;
        w_out_lane_nxt  = 1'b1;
        w_out_last_nxt  = 1'b1;
        w_out_data_nxt  = sext_half(w_lane1);
      end else begin
        w_out_valid_nxt = 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_lane  = r_out_lane;
  assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_packed_sum_unpacker.sv
// Scoreboard bench for packed_sum_unpacker: accepted words are expanded into expected
// beats by an arithmetic model; a monitor compares every presented beat.
module tb_packed_sum_unpacker;
  localparam int IW = 32;
  localparam int OW = 32;
  localparam int HW = IW / 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  packed_sum_unpacker_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  packed_sum_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [OW-1:0] data;
    logic          lane;
    logic          last;
  } beat_t;

  beat_t q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  bit    prev_rst = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Two's-complement value of a 'bits'-wide field, re-encoded at OW bits.
  function automatic logic [OW-1:0] sext(input longint v, input int bits);
    longint s;
    s = v;
    if (s >= (longint'(1) << (bits - 1))) s = s - (longint'(1) << bits);
    return OW'(s);
  endfunction

  function automatic void push_word(input logic [IW-1:0] d, input bit m);
    beat_t b;
    if (m) begin
      b.data = sext(longint'(d[HW-1:0]), HW);  b.lane = 1'b0; b.last = 1'b0; q.push_back(b);
      b.data = sext(longint'(d[IW-1:HW]), HW); b.lane = 1'b1; b.last = 1'b1; q.push_back(b);
    end else begin
      b.data = sext(longint'(d), IW);          b.lane = 1'b0; b.last = 1'b1; q.push_back(b);
    end
  endfunction

  // One clock of stimulus: drive after the edge, check in_ready mid-cycle, update model after the monitor.
  task automatic step(input bit v, input logic [IW-1:0] d, input bit m, input bit r,
                      input bit rst, output bit acc);
    bit exp_rdy;
    @(posedge clk);
    #1;
    if (prev_rst) begin
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_out_data",  64'(bus.out_data),  64'(0));
      chk("rst_out_lane",  64'(bus.out_lane),  64'(0));
      chk("rst_out_last",  64'(bus.out_last),  64'(0));
    end
    reset           = rst;
    bus.in_valid    = v;
    bus.in_data     = d;
    bus.choose_8bit = m;
    bus.out_ready   = rst ? 1'b0 : r;
    #3;
    exp_rdy = !rst && ((q.size() == 0) || (q.size() == 1 && r));
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    acc = v && (bus.in_ready === 1'b1);
    @(negedge clk);
    #1;
    if (rst) q.delete();
    else if (acc) push_word(d, m);
    prev_rst = rst;
  endtask

  task automatic send_word(input logic [IW-1:0] d, input bit m);
    bit acc;
    int n;
    n = 0;
    do begin
      step(1'b1, d, m, 1'b1, 1'b0, acc);
      n++;
    end while (!acc && n < 20);
    chk("accept_in_time", 64'(acc), 64'(1));
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'(0));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        if (bus.out_valid === 1'b1 && q.size() != 0) begin
          chk("out_data", 64'(bus.out_data), 64'(q[0].data));
          chk("out_lane", 64'(bus.out_lane), 64'(q[0].lane));
          chk("out_last", 64'(bus.out_last), 64'(q[0].last));
          if (bus.out_ready === 1'b1) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    bit            acc;
    bit            hold_v;
    logic [IW-1:0] hold_d;
    logic [IW-1:0] words [4];
    bit            v, m, r, rst;
    logic [IW-1:0] d;
    int            k;

    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.choose_8bit = 1'b0;
    bus.out_ready   = 1'b0;

    repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);

    send_word(32'h7FFF_8000, 1'b1);
    drain();

    send_word(32'h8000_0001, 1'b0);
    drain();

    words[0] = 32'h1111_8888; words[1] = 32'hFFFF_0000;
    words[2] = 32'h8000_7FFF; words[3] = 32'h0123_FEDC;
    for (int i = 0; i < 4; i++) send_word(words[i], 1'b1);
    drain();

    step(1'b1, 32'h0001_FFFF, 1'b1, 1'b0, 1'b0, acc);
    chk("stall_accept", 64'(acc), 64'(1));
    repeat (5) step(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
    drain();

    send_word(32'h1234_5678, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    send_word(32'h0002_0003, 1'b1);
    drain();

    send_word(32'hFFFE_0004, 1'b1);
    k = 0;
    do begin
      step(1'b1, 32'h0000_0010, (k % 2) == 0, 1'b1, 1'b0, acc);
      k++;
    end while (!acc && k < 20);
    chk("toggle_accept", 64'(acc), 64'(1));
    drain();

    hold_v = 1'b0;
    hold_d = '0;
    for (int i = 0; i < 400; i++) begin
      if (hold_v) begin
        v = 1'b1;
        d = hold_d;
      end else begin
        v = ($urandom % 4) != 0;
        d = $urandom;
        if ($urandom % 4 == 0)
          d = {(($urandom % 2) != 0) ? 16'h8000 : 16'h7FFF, (($urandom % 2) != 0) ? 16'hFFFF : 16'h0000};
      end
      m   = ($urandom % 2) != 0;
      r   = ($urandom % 4) != 0;
      rst = ($urandom % 60) == 0;
      step(v, d, m, r, rst, acc);
      hold_v = v && !acc && !rst;
      hold_d = d;
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
